// File: rtl/exc_int_ctrl_pkg.sv
// Shared types and defaults for the interrupt/exception controller.
// Holds the FSM state encodings and the default NMI source / edge mask.
package exc_int_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TAKE    = 2'd1,
        ST_HANDLER = 2'd2
    } ctrl_state_e;

    localparam int         NMI_SRC_DEF   = 0;
    localparam logic [7:0] EDGE_MASK_DEF = 8'h01;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins.
module exc_prio_enc #(
    parameter int NUM_SRC = 8,
    parameter int VEC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [VEC_W-1:0]   idx,
    output logic               vld
);

    always_comb begin
        idx = '0;
        vld = |req;
        // Scan from the top so the lowest set index is the last to overwrite idx.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) idx = VEC_W'(i);
        end
    end

endmodule

// File: rtl/exc_int_ctrl.sv
// Registered interrupt/exception controller: pending latch, masking, priority,
// take/return FSM with one level of NMI nesting and a 2-entry EPC stack.
module exc_int_ctrl
    import exc_int_ctrl_pkg::*;
#(
    parameter int                 NUM_SRC   = 8,
    parameter int                 VEC_W     = $clog2(NUM_SRC),
    parameter int                 NMI_SRC   = NMI_SRC_DEF,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = NUM_SRC'(EDGE_MASK_DEF),
    parameter int                 PC_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_req,
    input  logic [NUM_SRC-1:0] int_mask,
    input  logic               status_ie,
    input  logic               stall,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               int_ret,
    output logic               int_take,
    output logic [VEC_W-1:0]   int_vec,
    output logic [PC_W-1:0]    epc_out,
    output logic               exl,
    output logic               nested,
    output logic [NUM_SRC-1:0] pend_out
);

    localparam logic [NUM_SRC-1:0] NMI_OH = NUM_SRC'(1) << NMI_SRC;

    ctrl_state_e        state_q, state_d;
    logic [NUM_SRC-1:0] prev_q, pend_q, pend_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [PC_W-1:0]    stack0_q, stack0_d, stack1_q, stack1_d, epc_q, epc_d;
    logic               exl_q, exl_d, nested_q, nested_d, take_q, take_d;

    logic [NUM_SRC-1:0] elig, edge_set, clr;
    logic [VEC_W-1:0]   win;
    logic               win_vld;

    assign elig     = pend_q & ((int_mask & {NUM_SRC{status_ie}}) | NMI_OH);
    assign edge_set = src_req & ~prev_q & EDGE_MASK;

    exc_prio_enc #(.NUM_SRC(NUM_SRC), .VEC_W(VEC_W)) u_prio (
        .req (elig),
        .idx (win),
        .vld (win_vld)
    );

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        stack0_d = stack0_q;
        stack1_d = stack1_q;
        exl_d    = exl_q;
        nested_d = nested_q;
        take_d   = 1'b0;
        clr      = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (win_vld && !stall) begin
                    state_d  = ST_TAKE;
                    vec_d    = win;
                    stack0_d = pc_in;
                    exl_d    = 1'b1;
                    clr      = NUM_SRC'(1) << win;
                    take_d   = 1'b1;
                end
            end
            ST_TAKE: state_d = ST_HANDLER;
            ST_HANDLER: begin
                // A return wins over a pending NMI; the NMI is re-evaluated next cycle.
                if (int_ret) begin
                    if (nested_q) begin
                        nested_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        exl_d   = 1'b0;
                    end
                end else if (!nested_q && pend_q[NMI_SRC] && !stall) begin
                    state_d  = ST_TAKE;
                    stack1_d = pc_in;
                    nested_d = 1'b1;
                    vec_d    = VEC_W'(NMI_SRC);
                    clr      = NMI_OH;
                    take_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Edge bits: a new edge in the take cycle beats the clear. Level bits track the input.
        pend_d = (EDGE_MASK & ((pend_q & ~clr) | edge_set)) | (~EDGE_MASK & src_req);
        epc_d  = nested_d ? stack1_d : stack0_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            prev_q   <= '0;
            pend_q   <= '0;
            vec_q    <= '0;
            stack0_q <= '0;
            stack1_q <= '0;
            epc_q    <= '0;
            exl_q    <= 1'b0;
            nested_q <= 1'b0;
            take_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= src_req;
            pend_q   <= pend_d;
            vec_q    <= vec_d;
            stack0_q <= stack0_d;
            stack1_q <= stack1_d;
            epc_q    <= epc_d;
            exl_q    <= exl_d;
            nested_q <= nested_d;
            take_q   <= take_d;
        end
    end

    assign int_take = take_q;
    assign int_vec  = vec_q;
    assign epc_out  = epc_q;
    assign exl      = exl_q;
    assign nested   = nested_q;
    assign pend_out = pend_q;

endmodule

// File: tb/tb_exc_int_ctrl.sv
// Scoreboard bench for exc_int_ctrl: directed scenarios push expected takes,
// a negedge monitor pops and compares whenever int_take is seen.
module tb_exc_int_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  src_req, int_mask;
    logic        status_ie, stall, int_ret;
    logic [31:0] pc_in;
    logic        int_take;
    logic [2:0]  int_vec;
    logic [31:0] epc_out;
    logic        exl, nested;
    logic [7:0]  pend_out;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int          cyc;
        logic [2:0]  vec;
        logic [31:0] epc;
        logic        nested;
    } exp_t;
    exp_t exp_q[$];

    exc_int_ctrl #(.NUM_SRC(8), .VEC_W(3), .NMI_SRC(0), .EDGE_MASK(8'h0F), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .src_req(src_req), .int_mask(int_mask), .status_ie(status_ie),
        .stall(stall), .pc_in(pc_in), .int_ret(int_ret), .int_take(int_take), .int_vec(int_vec),
        .epc_out(epc_out), .exl(exl), .nested(nested), .pend_out(pend_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int c, input logic [2:0] v, input logic [31:0] e, input logic n);
        exp_t x;
        x.cyc = c; x.vec = v; x.epc = e; x.nested = n;
        exp_q.push_back(x);
    endtask

    task automatic ret();
        int_ret = 1'b1;
        tick(1);
        int_ret = 1'b0;
    endtask

    // Monitor: every int_take must match the oldest expected take.
    always @(negedge clk) begin
        if (rst === 1'b1 && int_take === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_take", {29'd0, int_vec}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("take_cycle", cyc, e.cyc);
                chk("take_vec", {29'd0, int_vec}, {29'd0, e.vec});
                chk("take_epc", epc_out, e.epc);
                chk("take_exl", {31'd0, exl}, 32'd1);
                chk("take_nested", {31'd0, nested}, {31'd0, e.nested});
            end
        end
    end

    initial begin
        rst = 1'b0; src_req = '0; int_mask = '0; status_ie = 1'b1;
        stall = 1'b0; int_ret = 1'b0; pc_in = '0;
        tick(3);
        chk("rst_take", {31'd0, int_take}, 0);
        chk("rst_exl", {31'd0, exl}, 0);
        chk("rst_pend", {24'd0, pend_out}, 0);
        chk("rst_epc", epc_out, 0);
        rst = 1'b1;
        tick(2);

        // T2 basic take on edge source 2
        int_mask = 8'h04; src_req = 8'h04; pc_in = 32'h100;
        push(cyc + 2, 3'd2, 32'h100, 1'b0);
        tick(1);
        chk("t2_pend_set", {24'd0, pend_out}, 32'h04);
        src_req = '0;
        tick(1);
        chk("t2_pend_clr", {24'd0, pend_out}, 0);
        chk("t2_exl", {31'd0, exl}, 1);
        chk("t2_vec", {29'd0, int_vec}, 2);
        tick(1);
        chk("t2_take_one_cycle", {31'd0, int_take}, 0);
        ret();
        chk("t2_ret_exl", {31'd0, exl}, 0);

        // T3 priority and mask
        int_mask = 8'h08; src_req = 8'h0C; pc_in = 32'h200;
        push(cyc + 2, 3'd3, 32'h200, 1'b0);
        tick(1);
        chk("t3_pend", {24'd0, pend_out}, 32'h0C);
        src_req = '0;
        tick(1);
        chk("t3_pend_left", {24'd0, pend_out}, 32'h04);
        tick(1);
        int_mask = 8'h0C;
        tick(2);
        pc_in = 32'h300;
        push(cyc + 2, 3'd2, 32'h300, 1'b0);
        ret();
        tick(2);
        ret();
        status_ie = 1'b0; int_mask = 8'h08; src_req = 8'h08;
        tick(1);
        src_req = '0;
        tick(5);
        chk("t3_ie0_pend", {24'd0, pend_out}, 32'h08);
        chk("t3_ie0_exl", {31'd0, exl}, 0);
        status_ie = 1'b1; pc_in = 32'h340;
        push(cyc + 1, 3'd3, 32'h340, 1'b0);
        tick(2);
        ret();

        // T4 stall holds the request; pc comes from the decision cycle
        stall = 1'b1; int_mask = 8'h04; src_req = 8'h04; pc_in = 32'h3F0;
        tick(1);
        src_req = '0;
        tick(5);
        chk("t4_pend_held", {24'd0, pend_out}, 32'h04);
        chk("t4_exl", {31'd0, exl}, 0);
        stall = 1'b0; pc_in = 32'h400;
        push(cyc + 1, 3'd2, 32'h400, 1'b0);
        tick(1);
        pc_in = 32'h999;
        tick(1);
        chk("t4_epc", epc_out, 32'h400);
        ret();

        // T5 NMI nesting
        int_mask = 8'h08; src_req = 8'h08; pc_in = 32'h200;
        push(cyc + 2, 3'd3, 32'h200, 1'b0);
        tick(1);
        src_req = '0;
        tick(2);
        src_req = 8'h01; pc_in = 32'h240;
        push(cyc + 2, 3'd0, 32'h240, 1'b1);
        tick(1);
        src_req = '0;
        tick(1);
        chk("t5_nested", {31'd0, nested}, 1);
        chk("t5_epc_nmi", epc_out, 32'h240);
        tick(1);
        ret();
        chk("t5_ret1_nested", {31'd0, nested}, 0);
        chk("t5_ret1_epc", epc_out, 32'h200);
        chk("t5_ret1_exl", {31'd0, exl}, 1);
        ret();
        chk("t5_ret2_exl", {31'd0, exl}, 0);
        chk("t5_pend", {24'd0, pend_out}, 0);

        // T6a return and pending NMI in the same cycle
        int_mask = 8'h08; src_req = 8'h08; pc_in = 32'h500;
        push(cyc + 2, 3'd3, 32'h500, 1'b0);
        tick(1);
        src_req = '0;
        tick(2);
        src_req = 8'h01;
        tick(1);
        src_req = '0; int_ret = 1'b1; pc_in = 32'h540;
        push(cyc + 2, 3'd0, 32'h540, 1'b0);
        tick(1);
        int_ret = 1'b0;
        chk("t6a_ret_first", {31'd0, exl}, 0);
        tick(2);
        ret();

        // T6b re-edge on the source being taken keeps it pending
        int_mask = 8'h04; src_req = 8'h04; pc_in = 32'h700;
        tick(1);
        src_req = '0; stall = 1'b1;
        tick(1);
        stall = 1'b0; src_req = 8'h04;
        push(cyc + 1, 3'd2, 32'h700, 1'b0);
        tick(1);
        chk("t6b_pend_kept", {24'd0, pend_out}, 32'h04);
        src_req = '0;
        tick(1);
        pc_in = 32'h780;
        push(cyc + 2, 3'd2, 32'h780, 1'b0);
        ret();
        tick(1);
        chk("t6b_pend_clr", {24'd0, pend_out}, 0);
        tick(1);
        ret();

        // T1 reset mid-handler
        int_mask = 8'h08; src_req = 8'h08; pc_in = 32'h600;
        push(cyc + 2, 3'd3, 32'h600, 1'b0);
        tick(1);
        src_req = 8'h04;
        tick(2);
        chk("t1_pre_pend", {24'd0, pend_out}, 32'h04);
        rst = 1'b0;
        #1;
        chk("t1_take", {31'd0, int_take}, 0);
        chk("t1_vec", {29'd0, int_vec}, 0);
        chk("t1_epc", epc_out, 0);
        chk("t1_exl", {31'd0, exl}, 0);
        chk("t1_nested", {31'd0, nested}, 0);
        chk("t1_pend", {24'd0, pend_out}, 0);
        src_req = '0;
        tick(2);
        rst = 1'b1;
        tick(1);
        ret();
        tick(3);
        chk("t1_idle_exl", {31'd0, exl}, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
